// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//   Pointer/flag controller sitting directly upstream of a dual-port
//   DATA_WIDTH x 2**ADDR_WIDTH memory. Together with that memory it forms one
//   transaction-layer FIFO: push/pop requests become memory accesses, the
//   occupancy is tracked, status flags are derived and the memory's
//   registered read data is returned with a one-cycle valid strobe.
//
// Ports
//   clk           in   system clock, all state updates on the rising edge
//   reset_L       in   asynchronous active-low reset
//   push, pop     in   write / read requests
//   data_in       in   word to store
//   umbral_alto   in   almost-full threshold (entries)
//   umbral_bajo   in   almost-empty threshold (entries)
//   mem_data_out  in   registered read data from the memory
//   mem_wr_en     out  memory write enable (accepted push)
//   mem_rd_en     out  memory read enable (accepted pop)
//   mem_wr_add    out  memory write address (write pointer)
//   mem_rd_add    out  memory read address (read pointer)
//   mem_data_in   out  memory write data (pass-through of data_in)
//   data_out      out  popped word, held between pops
//   valid_out     out  data_out carries a newly popped word this cycle
//   count         out  occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty  out  status flags
//   fifo_error    out  sticky overflow/underflow indicator
// -----------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_add,
  output logic [ADDR_WIDTH-1:0] mem_rd_add,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  // DEPTH = 2**ADDR_WIDTH expressed at the width of the count register.
  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic                  error_q,  error_d;
  logic                  valid_q,  valid_d;
  logic [DATA_WIDTH-1:0] hold_q,   hold_d;

  logic full_s;
  logic empty_s;
  logic push_ok_s;
  logic pop_ok_s;

  // Status flags and request acceptance, all from registered occupancy.
  always_comb begin
    empty_s   = (count_q == {(ADDR_WIDTH+1){1'b0}});
    full_s    = (count_q == DEPTH);
    // Full FIFO rejects the push, empty FIFO rejects the pop: no
    // write-through and no bypass in either corner.
    push_ok_s = push & ~full_s;
    pop_ok_s  = pop  & ~empty_s;
  end

  // Next-state for pointers, occupancy, sticky error and read-data holding.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;   // wraps naturally at DEPTH-1
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;      // idle, or push and pop together
    endcase
    // A rejected request only sets the sticky error; it never clears.
    error_d = error_q | (push & full_s) | (pop & empty_s);
    valid_d = pop_ok_s;
    // The memory presents fresh data during the valid cycle; capture it so
    // data_out keeps showing the last popped word afterwards.
    if (valid_q) begin
      hold_d = mem_data_out;
    end else begin
      hold_d = hold_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q <= {ADDR_WIDTH{1'b0}};
      count_q  <= {(ADDR_WIDTH+1){1'b0}};
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
      hold_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
      hold_q   <= hold_d;
    end
  end

  // Memory interface: enables are gated by reset so nothing is written or
  // read while reset_L is held low, whatever push/pop do.
  assign mem_wr_en    = push_ok_s & reset_L;
  assign mem_rd_en    = pop_ok_s  & reset_L;
  assign mem_wr_add   = wr_ptr_q;
  assign mem_rd_add   = rd_ptr_q;
  assign mem_data_in  = data_in;

  // Read return path: one cycle after an accepted pop.
  assign valid_out    = valid_q;
  assign data_out     = valid_q ? mem_data_out : hold_q;

  assign count        = count_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_q >= umbral_alto);
  assign almost_empty = (count_q <= umbral_bajo);
  assign fifo_error   = error_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

  localparam int DW = 10;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset_L;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [AW:0]   umbral_alto;
  logic [AW:0]   umbral_bajo;
  logic [DW-1:0] mem_data_out;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [AW-1:0] mem_wr_add;
  logic [AW-1:0] mem_rd_add;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          fifo_error;

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .mem_data_out (mem_data_out),
    .mem_wr_en    (mem_wr_en),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_add   (mem_wr_add),
    .mem_rd_add   (mem_rd_add),
    .mem_data_in  (mem_data_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_error   (fifo_error)
  );

  // Behavioural dual-port memory with registered read data.
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_add] <= mem_data_in;
    if (mem_rd_en) mem_data_out <= mem[mem_rd_add];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_err;
  int n_checks;

  // Reference model state.
  int            m_count;
  int            m_wptr;
  int            m_rptr;
  bit            m_err;
  logic [DW-1:0] m_last;
  logic [DW-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_wptr  = 0;
    m_rptr  = 0;
    m_err   = 1'b0;
    m_last  = '0;
    sb.delete();
  endtask

  task automatic chk_status();
    chk("count",        32'(count),        32'(m_count));
    chk("empty",        32'(empty),        32'(m_count == 0));
    chk("full",         32'(full),         32'(m_count == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(m_count >= int'(umbral_alto)));
    chk("almost_empty", 32'(almost_empty), 32'(m_count <= int'(umbral_bajo)));
    chk("fifo_error",   32'(fifo_error),   32'(m_err));
  endtask

  // One clock cycle: drive just after a falling edge, check the combinational
  // memory interface, advance one rising edge and check the return path.
  task automatic step(input bit p, input bit q, input logic [DW-1:0] d);
    bit pok;
    bit qok;
    logic [DW-1:0] e;
    push = p; pop = q; data_in = d;
    #1;
    pok = p && (m_count != DEPTH);
    qok = q && (m_count != 0);
    chk("mem_wr_en", 32'(mem_wr_en), 32'(pok));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(qok));
    if (pok) begin
      chk("mem_wr_add",  32'(mem_wr_add),  32'(m_wptr));
      chk("mem_data_in", 32'(mem_data_in), 32'(d));
      sb.push_back(d);
    end
    if (qok) chk("mem_rd_add", 32'(mem_rd_add), 32'(m_rptr));
    if ((p && m_count == DEPTH) || (q && m_count == 0)) m_err = 1'b1;
    m_count = m_count + int'(pok) - int'(qok);
    m_wptr  = (m_wptr + int'(pok)) % DEPTH;
    m_rptr  = (m_rptr + int'(qok)) % DEPTH;
    @(posedge clk);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    chk("valid_out", 32'(valid_out), 32'(qok));
    if (qok) begin
      e = sb.pop_front();
      m_last = e;
    end
    chk("data_out", 32'(data_out), 32'(m_last));
    chk_status();
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    model_reset();
    reset_L = 1'b0;
    push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_alto = 5'd6; umbral_bajo = 5'd2;
    #1;
    chk_status();
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    // Requests while in reset must not reach the memory.
    push = 1'b1; pop = 1'b1; data_in = 10'h155;
    #1;
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    reset_L = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'h000);

    // Six pushes, then four pops with one-cycle read latency.
    step(1'b1, 1'b0, 10'h0FF);
    step(1'b1, 1'b0, 10'h011);
    step(1'b1, 1'b0, 10'h022);
    step(1'b1, 1'b0, 10'h033);
    step(1'b1, 1'b0, 10'h044);
    step(1'b1, 1'b0, 10'h055);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 10'h000);
    step(1'b0, 1'b0, 10'h000);          // data_out holds after valid drops
    step(1'b0, 1'b1, 10'h000);
    step(1'b0, 1'b1, 10'h000);

    // Fill to 16, then overflow attempt.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(10'h100 + i));
    step(1'b1, 1'b0, 10'h3AA);
    step(1'b0, 1'b1, 10'h000);          // returns first word, not 0x3AA

    // Full with simultaneous push and pop: only the read happens.
    step(1'b1, 1'b0, 10'h2C0);
    step(1'b1, 1'b1, 10'h2C1);
    // Drain, then simultaneous push and pop on empty: only the write happens.
    while (m_count > 0) step(1'b0, 1'b1, 10'h000);
    step(1'b1, 1'b1, 10'h2D5);
    step(1'b0, 1'b1, 10'h000);

    // 20 words with interleaved push/pop; pointers wrap through 15 -> 0.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, DW'($urandom_range(0, 1023)));
      if (i % 3 == 2) step(1'b0, 1'b1, 10'h000);
    end
    while (m_count > 0) step(1'b0, 1'b1, 10'h000);

    // Asynchronous reset mid-stream with count=5 and valid_out high.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(10'h0A0 + i));
    step(1'b0, 1'b1, 10'h000);
    chk("pre_rst_valid", 32'(valid_out), 32'd1);
    #2;
    reset_L = 1'b0;
    push = 1'b1; pop = 1'b1;
    #1;
    model_reset();
    chk_status();
    chk("async_valid_out", 32'(valid_out), 32'd0);
    chk("async_data_out",  32'(data_out),  32'd0);
    chk("async_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("async_mem_rd_en", 32'(mem_rd_en), 32'd0);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    reset_L = 1'b1;
    step(1'b1, 1'b0, 10'h123);          // must write address 0
    step(1'b0, 1'b1, 10'h000);
    step(1'b0, 1'b0, 10'h000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
